// File: rtl/pc_seq_if.sv
// pc_seq_if
//   Controller <-> program-counter bundle.  The controller (master) issues
//   stall / increment / jump / call / return requests plus the jump or call
//   operand.  The program counter (slave) returns the current PC, a redirect
//   pulse, and the return-stack status and error flags.
// Parameters
//   AW        PC / address width
//   DW        operand (data bus) width
//   STK_DEPTH return-stack entries
// Signals (master -> slave)
//   hold, inc, jmp_en, jmp_cond, jmp_rel, call, ret, err_clr, din[DW]
// Signals (slave -> master)
//   pc_out[AW], redirect, stk_level, stk_full, stk_empty, err_ovf, err_unf
interface pc_seq_if #(
   parameter int AW        = 6,
   parameter int DW        = 8,
   parameter int STK_DEPTH = 4
) ();
   localparam int LW = $clog2(STK_DEPTH + 1);

   logic          hold;
   logic          inc;
   logic          jmp_en;
   logic          jmp_cond;
   logic          jmp_rel;
   logic          call;
   logic          ret;
   logic          err_clr;
   logic [DW-1:0] din;
   logic [AW-1:0] pc_out;
   logic          redirect;
   logic [LW-1:0] stk_level;
   logic          stk_full;
   logic          stk_empty;
   logic          err_ovf;
   logic          err_unf;

   modport master (
      output hold, inc, jmp_en, jmp_cond, jmp_rel, call, ret, err_clr, din,
      input  pc_out, redirect, stk_level, stk_full, stk_empty, err_ovf, err_unf
   );

   modport slave (
      input  hold, inc, jmp_en, jmp_cond, jmp_rel, call, ret, err_clr, din,
      output pc_out, redirect, stk_level, stk_full, stk_empty, err_ovf, err_unf
   );
endinterface

// File: rtl/pc_seq_stack.sv
// pc_seq_stack
//   Parametrised program counter with conditional absolute/relative jumps and
//   a hardware call/return stack with sticky overflow/underflow flags.
//   One request is served per clock edge, priority hold > ret > call >
//   taken jump > inc > keep.
// Ports
//   clk   in  system clock, rising edge
//   rst   in  asynchronous reset, active-low
//   bus   pc_seq_if.slave: requests/operand in, PC and stack status out
module pc_seq_stack #(
   parameter int            AW        = 6,
   parameter int            DW        = 8,
   parameter int            STK_DEPTH = 4,
   parameter logic [AW-1:0] RST_ADDR  = '0
) (
   input  logic    clk,
   input  logic    rst,
   pc_seq_if.slave bus
);
   localparam int LW = $clog2(STK_DEPTH + 1);
   // Stack index width; a one-entry stack still needs a 1-bit index.
   localparam int IW = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
   localparam int SN = 1 << IW;
   localparam logic [LW-1:0] DEPTH_L = LW'(STK_DEPTH);

   if (DW < AW) begin : g_width_check
      $error("pc_seq_stack: DW must be >= AW");
   end

   logic [AW-1:0] pc;
   logic [AW-1:0] pc_nxt;
   logic [AW-1:0] pc_inc;
   logic [AW-1:0] operand;
   logic [LW-1:0] level;
   logic [LW-1:0] level_nxt;
   logic [LW-1:0] level_m1;
   logic          redirect;
   logic          redirect_nxt;
   logic          err_ovf;
   logic          err_unf;
   logic          ovf_set;
   logic          unf_set;
   logic          push;
   logic          full;
   logic          empty;
   logic [IW-1:0] push_idx;
   logic [IW-1:0] pop_idx;
   logic [AW-1:0] stack [SN];
   logic          unused_bits;

   assign operand  = bus.din[AW-1:0];
   assign pc_inc   = pc + AW'(1'b1);
   assign level_m1 = level - LW'(1'b1);
   assign full     = (level == DEPTH_L);
   assign empty    = (level == {LW{1'b0}});
   // level < STK_DEPTH on push and level >= 1 on pop, so the low bits index safely.
   assign push_idx = level[IW-1:0];
   assign pop_idx  = level_m1[IW-1:0];
   // Collects bits that are intentionally never read (upper operand bits etc.).
   assign unused_bits = ^{bus.din, level_m1};

   // Next-state selection: only the highest-priority request acts.
   always_comb begin
      pc_nxt       = pc;
      level_nxt    = level;
      redirect_nxt = 1'b0;
      push         = 1'b0;
      ovf_set      = 1'b0;
      unf_set      = 1'b0;
      if (bus.hold) begin
         pc_nxt = pc;
      end else if (bus.ret) begin
         if (!empty) begin
            pc_nxt       = stack[pop_idx];
            level_nxt    = level_m1;
            redirect_nxt = 1'b1;
         end else begin
            unf_set = 1'b1;
         end
      end else if (bus.call) begin
         if (!full) begin
            push         = 1'b1;
            pc_nxt       = operand;
            level_nxt    = level + LW'(1'b1);
            redirect_nxt = 1'b1;
         end else begin
            ovf_set = 1'b1;
         end
      end else if (bus.jmp_en && bus.jmp_cond) begin
         // Relative: AW-bit two's-complement add, truncation gives the wrap.
         if (bus.jmp_rel) begin
            pc_nxt = pc + operand;
         end else begin
            pc_nxt = operand;
         end
         redirect_nxt = 1'b1;
      end else if (bus.inc) begin
         pc_nxt = pc_inc;
      end else begin
         pc_nxt = pc;
      end
   end

   // PC, stack level, redirect pulse and sticky error flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc       <= RST_ADDR;
         level    <= {LW{1'b0}};
         redirect <= 1'b0;
         err_ovf  <= 1'b0;
         err_unf  <= 1'b0;
      end else begin
         pc       <= pc_nxt;
         level    <= level_nxt;
         redirect <= redirect_nxt;
         // A new error on the same edge as err_clr wins.
         err_ovf  <= ovf_set | (err_ovf & ~bus.err_clr);
         err_unf  <= unf_set | (err_unf & ~bus.err_clr);
      end
   end

   // Return-address storage; contents are only read below the level pointer.
   always_ff @(posedge clk) begin
      if (push) begin
         stack[push_idx] <= pc_inc;
      end
   end

   assign bus.pc_out    = pc;
   assign bus.redirect  = redirect;
   assign bus.stk_level = level;
   assign bus.stk_full  = full;
   assign bus.stk_empty = empty;
   assign bus.err_ovf   = err_ovf;
   assign bus.err_unf   = err_unf;
endmodule

// File: tb/tb_pc_seq_stack.sv
// tb_pc_seq_stack
//   Self-checking bench for pc_seq_stack (AW=6, DW=8, STK_DEPTH=4).
//   Each stimulus row pushes the reference model's expected outputs into a
//   queue; the row's task pops and compares once the edge has happened.
//   Row layout: [15]hold [14]inc [13]jmp_en [12]jmp_cond [11]jmp_rel
//               [10]call [9]ret [8]err_clr [7:0]din
module tb_pc_seq_stack;
   localparam logic [15:0] H  = 16'h8000;
   localparam logic [15:0] I  = 16'h4000;
   localparam logic [15:0] JE = 16'h2000;
   localparam logic [15:0] JC = 16'h1000;
   localparam logic [15:0] JR = 16'h0800;
   localparam logic [15:0] CA = 16'h0400;
   localparam logic [15:0] RE = 16'h0200;
   localparam logic [15:0] CL = 16'h0100;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [5:0]  m_pc;
   logic [5:0]  m_stk[$];
   logic        m_redir;
   logic        m_ovf;
   logic        m_unf;
   logic [14:0] sb[$];

   pc_seq_if #(.AW(6), .DW(8), .STK_DEPTH(4)) bus ();

   pc_seq_stack #(.AW(6), .DW(8), .STK_DEPTH(4), .RST_ADDR(6'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] obs();
      return {bus.pc_out, bus.redirect, bus.stk_level, bus.stk_full,
              bus.stk_empty, bus.err_ovf, bus.err_unf};
   endfunction

   function automatic logic [14:0] exp_vec();
      return {m_pc, m_redir, 3'(m_stk.size()), (m_stk.size() == 4),
              (m_stk.size() == 0), m_ovf, m_unf};
   endfunction

   task automatic model_reset();
      m_pc    = 6'h00;
      m_stk.delete();
      m_redir = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   // Drive one row, predict the result, push it, and advance past the edge.
   task automatic apply(input logic [15:0] r);
      logic [5:0] d;
      logic       so;
      logic       su;
      bus.hold     = r[15];
      bus.inc      = r[14];
      bus.jmp_en   = r[13];
      bus.jmp_cond = r[12];
      bus.jmp_rel  = r[11];
      bus.call     = r[10];
      bus.ret      = r[9];
      bus.err_clr  = r[8];
      bus.din      = r[7:0];
      d       = r[5:0];
      so      = 1'b0;
      su      = 1'b0;
      m_redir = 1'b0;
      if (!r[15]) begin
         if (r[9]) begin
            if (m_stk.size() > 0) begin
               m_pc    = m_stk.pop_back();
               m_redir = 1'b1;
            end else begin
               su = 1'b1;
            end
         end else if (r[10]) begin
            if (m_stk.size() < 4) begin
               m_stk.push_back(6'(m_pc + 6'd1));
               m_pc    = d;
               m_redir = 1'b1;
            end else begin
               so = 1'b1;
            end
         end else if (r[13] && r[12]) begin
            m_pc    = r[11] ? 6'(m_pc + d) : d;
            m_redir = 1'b1;
         end else if (r[14]) begin
            m_pc = 6'(m_pc + 6'd1);
         end
      end
      m_ovf = so | (m_ovf & ~r[8]);
      m_unf = su | (m_unf & ~r[8]);
      sb.push_back(exp_vec());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [14:0] o;
      o = obs();
      total++;
      if (o !== {6'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_state: got %h want %h", o,
                  {6'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
      end
   endtask

   task automatic test_inc();
      logic [15:0] seq[$];
      logic [14:0] e;
      logic [14:0] o;
      seq = '{JE | JC | 16'h003F, I, H | I, I, H | I, 16'h0000};
      foreach (seq[i]) begin
         apply(seq[i]);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL inc step %0d: got %h want %h", i, o, e);
         end
      end
      total++;
      if (bus.pc_out !== 6'h01 || bus.redirect !== 1'b0) begin
         bad++;
         $display("FAIL inc_wrap_final: got pc=%h redir=%b want pc=01 redir=0",
                  bus.pc_out, bus.redirect);
      end
   endtask

   task automatic test_jump();
      logic [15:0] seq[$];
      logic [14:0] e;
      logic [14:0] o;
      seq = '{JE | JC | 16'h0005, JE | I | 16'h0020, JE | JC | 16'h0020,
              JE | JC | 16'h0010, JE | JC | JR | 16'h003E, JE | JC | JR | 16'h00C2,
              JE | JC | 16'h003E, JE | JC | JR | 16'h0005, JE | 16'h0011};
      foreach (seq[i]) begin
         apply(seq[i]);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL jump step %0d: got %h want %h", i, o, e);
         end
      end
      total++;
      if (bus.pc_out !== 6'h03) begin
         bad++;
         $display("FAIL jump_final: got pc=%h want 03", bus.pc_out);
      end
   endtask

   task automatic test_calls();
      logic [15:0] seq[$];
      logic [14:0] e;
      logic [14:0] o;
      seq = '{CA | 16'h0010, CA | 16'h0020, RE, RE};
      foreach (seq[i]) begin
         apply(seq[i]);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL calls step %0d: got %h want %h", i, o, e);
         end
      end
      total++;
      if (bus.pc_out !== 6'h04 || bus.stk_empty !== 1'b1) begin
         bad++;
         $display("FAIL calls_final: got pc=%h empty=%b want pc=04 empty=1",
                  bus.pc_out, bus.stk_empty);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] seq[$];
      logic [14:0] e;
      logic [14:0] o;
      seq = '{CA | 16'h0001, CA | 16'h0002, CA | 16'h0003, CA | 16'h0004,
              CA | 16'h0005, CA | CL | 16'h0006, H | CA | 16'h0007,
              RE, RE, RE, RE, RE, CL, RE | CL, H | CL};
      foreach (seq[i]) begin
         apply(seq[i]);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL overflow step %0d: got %h want %h", i, o, e);
         end
      end
      total++;
      if (bus.pc_out !== 6'h05 || bus.err_ovf !== 1'b0 || bus.err_unf !== 1'b0) begin
         bad++;
         $display("FAIL overflow_final: got pc=%h ovf=%b unf=%b want pc=05 ovf=0 unf=0",
                  bus.pc_out, bus.err_ovf, bus.err_unf);
      end
   endtask

   task automatic test_priority();
      logic [15:0] seq[$];
      logic [14:0] e;
      logic [14:0] o;
      seq = '{CA | 16'h0008, RE | CA | JE | JC | I | 16'h0030,
              CA | JE | JC | 16'h0015, RE};
      foreach (seq[i]) begin
         apply(seq[i]);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL priority step %0d: got %h want %h", i, o, e);
         end
      end
      total++;
      if (bus.pc_out !== 6'h07 || bus.stk_level !== 3'd0) begin
         bad++;
         $display("FAIL priority_final: got pc=%h level=%0d want pc=07 level=0",
                  bus.pc_out, bus.stk_level);
      end
   endtask

   task automatic test_mid_reset();
      logic [15:0] seq[$];
      logic [14:0] e;
      logic [14:0] o;
      seq = '{CA | 16'h0010, CA | 16'h001A};
      foreach (seq[i]) begin
         apply(seq[i]);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL mid_reset_setup step %0d: got %h want %h", i, o, e);
         end
      end
      #2;
      rst = 1'b0;
      #1;
      o = obs();
      total++;
      if (o !== {6'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL mid_reset_async: got %h want %h", o,
                  {6'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
      end
      bus.hold = 1'b0; bus.inc = 1'b0; bus.jmp_en = 1'b0; bus.jmp_cond = 1'b0;
      bus.jmp_rel = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.err_clr = 1'b0;
      bus.din = 8'h00;
      #2;
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      apply(I);
      e = sb.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL mid_reset_after: got %h want %h", o, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] r;
      logic [14:0] e;
      logic [14:0] o;
      for (int i = 0; i < 200; i++) begin
         r = 16'($urandom);
         if ($urandom_range(3) != 0) r[15] = 1'b0;
         apply(r);
         e = sb.pop_front();
         o = obs();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL back_to_back step %0d row %h: got %h want %h", i, r, o, e);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      bus.hold = 1'b0; bus.inc = 1'b0; bus.jmp_en = 1'b0; bus.jmp_cond = 1'b0;
      bus.jmp_rel = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.err_clr = 1'b0;
      bus.din = 8'h00;
      model_reset();
      #12;
      test_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      test_inc();
      test_jump();
      test_calls();
      test_overflow();
      test_priority();
      test_mid_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
